// File: rtl/m_spi_pkg.sv
// Shared definitions for the SPI frame scheduler: FSM encoding, SPI mode and
// default frame geometry.
package m_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  // Mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on the rising edge).
  localparam int   SPI_MODE = 0;
  localparam logic SCK_IDLE = 1'b0;

  localparam int DEF_WORD    = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/m_spi_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the one-hot
// pointer, wrapping around.
module m_rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] pointer,
  output logic [N-1:0] winner,
  output logic         any
);

  // Walk the request vector twice so the scan can wrap past the top bit.
  always_comb begin
    logic seen;
    int   i;
    winner = '0;
    seen   = 1'b0;
    i      = 0;
    for (int k = 0; k < 2 * N; k++) begin
      i = (k < N) ? k : k - N;
      if (pointer[i]) seen = 1'b1;
      if (seen && req[i] && (winner == '0)) winner[i] = 1'b1;
    end
  end

  assign any = |req;

endmodule

// File: rtl/m_spi_sched.sv
// SPI master frame scheduler: round-robin grant among requesters, then one
// mode-0 frame (MSB first) per grant with a guaranteed ss_n gap between frames.
module m_spi_sched
  import m_spi_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int WORD    = DEF_WORD,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int SS_GAP  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*WORD-1:0] wdata,
  input  logic                  sleep,
  input  logic                  miso,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [WORD-1:0]       rdata,
  output logic                  busy,
  output logic                  ss_n,
  output logic                  sck,
  output logic                  mosi
);

  localparam int CNT_MAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(2 * WORD + 1);

  localparam logic [CW-1:0] DIV_LAST    = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(SS_GAP - 1);
  localparam logic [HW-1:0] H_LAST_FALL = HW'(2 * WORD - 1);
  localparam logic [HW-1:0] H_END       = HW'(2 * WORD);

  state_t            state_reg;
  logic [CW-1:0]     cnt_reg;
  logic [HW-1:0]     hcnt_reg;
  logic [N_REQ-1:0]  ptr_reg;
  logic [N_REQ-1:0]  owner_reg;
  logic [WORD-1:0]   tx_reg;
  logic [WORD-1:0]   rx_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [N_REQ-1:0]  done_reg;
  logic [WORD-1:0]   rdata_reg;
  logic              busy_reg;
  logic              ss_n_reg;
  logic              sck_reg;
  logic              mosi_reg;

  logic [N_REQ-1:0]  winner;
  logic              any_req;
  logic [WORD-1:0]   wsel;
  logic              tick;

  m_rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req),
    .pointer (ptr_reg),
    .winner  (winner),
    .any     (any_req)
  );

  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) wsel = wsel | wdata[i*WORD +: WORD];
    end
  end

  assign tick = (cnt_reg == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hcnt_reg  <= '0;
      ptr_reg   <= N_REQ'(1);
      owner_reg <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      gnt_reg   <= '0;
      done_reg  <= '0;
      rdata_reg <= '0;
      busy_reg  <= 1'b0;
      ss_n_reg  <= 1'b1;
      sck_reg   <= SCK_IDLE;
      mosi_reg  <= 1'b0;
    end else begin
      gnt_reg  <= '0;
      done_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (any_req && !sleep) begin
            gnt_reg   <= winner;
            owner_reg <= winner;
            ptr_reg   <= {winner[N_REQ-2:0], winner[N_REQ-1]};
            tx_reg    <= wsel;
            mosi_reg  <= wsel[WORD-1];
            ss_n_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          if (tick) begin
            cnt_reg   <= '0;
            sck_reg   <= ~SCK_IDLE;
            rx_reg    <= {rx_reg[WORD-2:0], miso};
            hcnt_reg  <= HW'(1);
            state_reg <= XFER;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        XFER: begin
          // hcnt counts sck toggles; after the last fall one more low half-period runs.
          if (tick) begin
            cnt_reg <= '0;
            if (hcnt_reg == H_END) begin
              state_reg <= HOLD;
            end else begin
              hcnt_reg <= hcnt_reg + 1'b1;
              if (sck_reg != SCK_IDLE) begin
                sck_reg <= SCK_IDLE;
                if (hcnt_reg != H_LAST_FALL) begin
                  tx_reg   <= tx_reg << 1;
                  mosi_reg <= tx_reg[WORD-2];
                end
              end else begin
                sck_reg <= ~SCK_IDLE;
                rx_reg  <= {rx_reg[WORD-2:0], miso};
              end
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (tick) begin
            cnt_reg   <= '0;
            ss_n_reg  <= 1'b1;
            done_reg  <= owner_reg;
            rdata_reg <= rx_reg;
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_reg;
  assign done  = done_reg;
  assign rdata = rdata_reg;
  assign busy  = busy_reg;
  assign ss_n  = ss_n_reg;
  assign sck   = sck_reg;
  assign mosi  = mosi_reg;

endmodule
